// File: rtl/down_counter_reload_pkg.sv
// Shared encodings for the reloadable down counter/timer.
package down_counter_reload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_counter_reload_if.sv
// Control/status bundle between a controller and the down counter.
interface down_counter_reload_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             load;
  logic [WIDTH-1:0] d;
  logic             start;
  logic             ce;
  logic             mode;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, d, start, ce, mode,
    input  q, tc, busy, done
  );

  modport slave (
    input  load, d, start, ce, mode,
    output q, tc, busy, done
  );

endinterface

// File: rtl/down_counter_reload_core.sv
// WIDTH-bit count register with clear, load and decrement, plus zero detect.
module down_counter_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             c,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             zero_c
);

  always_ff @(posedge c) begin
    if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (dec) begin
      q <= q - WIDTH'(1);
    end
  end

  assign zero_c = (q == '0);

endmodule

// File: rtl/down_counter_reload.sv
// Programmable interval timer: counts a reload value down to zero, one-shot or periodic.
module down_counter_reload
  import down_counter_reload_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  c,
  input  logic                  clr,
  down_counter_reload_if.slave  bus
);

  state_e           state, state_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic             tc_q, tc_n;
  logic             busy_q, done_q;

  logic             core_ld;
  logic [WIDTH-1:0] core_ld_val;
  logic             core_dec;
  logic [WIDTH-1:0] cnt;
  logic             cnt_zero_c;

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .c      (c),
    .clr    (clr),
    .ld     (core_ld),
    .ld_val (core_ld_val),
    .dec    (core_dec),
    .q      (cnt),
    .zero_c (cnt_zero_c)
  );

  // State, reload and status registers; busy/done are registered copies of the next state.
  always_ff @(posedge c) begin
    if (clr) begin
      state  <= ST_IDLE;
      reload <= '0;
      tc_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      reload <= reload_n;
      tc_q   <= tc_n;
      busy_q <= (state_n == ST_RUN);
      done_q <= (state_n == ST_DONE);
    end
  end

  // Next-state and counter control; LOAD outranks START, START outranks counting.
  always_comb begin
    state_n     = state;
    reload_n    = reload;
    tc_n        = 1'b0;
    core_ld     = 1'b0;
    core_ld_val = reload;
    core_dec    = 1'b0;

    if (bus.load) begin
      reload_n    = bus.d;
      core_ld     = 1'b1;
      core_ld_val = bus.d;
      state_n     = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            core_ld = 1'b1;
            state_n = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.ce) begin
            if (cnt_zero_c) begin
              tc_n = 1'b1;
              // Mode is sampled here so a mid-run change applies at this terminal count.
              if (bus.mode == MODE_ONESHOT) begin
                state_n = ST_DONE;
              end else begin
                core_ld = 1'b1;
              end
            end else begin
              core_dec = 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.q    = cnt;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// Self-checking bench for down_counter_reload: vector table through a scoreboard plus timing sequences.
module tb_down_counter_reload;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
  } out_t;

  typedef struct {
    logic         clr;
    logic         load;
    logic [W-1:0] d;
    logic         start;
    logic         ce;
    logic         mode;
    out_t         exp;
  } vec_t;

  logic c;
  logic clr;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  vec_t tbl[$];
  out_t sb[$];

  down_counter_reload_if #(.WIDTH(W)) bus ();

  down_counter_reload #(.WIDTH(W)) dut (
    .c   (c),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  always @(posedge c) cyc <= cyc + 1;

  task automatic add(input logic cl, input logic ld, input logic [W-1:0] dv, input logic st,
                     input logic en, input logic md, input logic [W-1:0] eq, input logic etc,
                     input logic eb, input logic ed);
    vec_t v;
    v.clr = cl; v.load = ld; v.d = dv; v.start = st; v.ce = en; v.mode = md;
    v.exp = '{q: eq, tc: etc, busy: eb, done: ed};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expected outputs, then score after the edge.
  task automatic apply(input vec_t v, input string name);
    out_t act, exp;
    clr = v.clr; bus.load = v.load; bus.d = v.d;
    bus.start = v.start; bus.ce = v.ce; bus.mode = v.mode;
    sb.push_back(v.exp);
    @(posedge c);
    #1;
    act = '{q: bus.q, tc: bus.tc, busy: bus.busy, done: bus.done};
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check(name, 32'(act), 32'(exp));
    end
  endtask

  task automatic step(input logic ld, input logic [W-1:0] dv, input logic st, input logic en,
                      input logic md, input logic [W-1:0] eq, input logic etc,
                      input logic eb, input logic ed, input string name);
    vec_t v;
    v.clr = 1'b0; v.load = ld; v.d = dv; v.start = st; v.ce = en; v.mode = md;
    v.exp = '{q: eq, tc: etc, busy: eb, done: ed};
    apply(v, name);
  endtask

  initial begin
    int tc_seen;
    int last_tc;
    n_cmp = 0; n_bad = 0; cyc = 0;
    clr = 1'b1; bus.load = 1'b0; bus.d = '0; bus.start = 1'b0; bus.ce = 1'b0; bus.mode = 1'b0;

    //   clr ld  d     st  ce  md   q     tc  bsy dn
    add(1, 1, 4'd7, 0, 1, 0,  4'd0, 0, 0, 0);   // load during clear ignored
    add(1, 0, 4'd0, 1, 1, 0,  4'd0, 0, 0, 0);
    add(0, 0, 4'd0, 1, 1, 0,  4'd0, 0, 1, 0);   // reload still 0 after clear
    add(0, 0, 4'd0, 0, 1, 0,  4'd0, 1, 0, 1);
    add(0, 0, 4'd0, 0, 1, 0,  4'd0, 0, 0, 1);
    // one-shot, reload 3
    add(0, 1, 4'd3, 0, 0, 0,  4'd3, 0, 0, 0);
    add(0, 0, 4'd0, 1, 0, 0,  4'd3, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 0,  4'd2, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 0,  4'd1, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 0,  4'd0, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 0,  4'd0, 1, 0, 1);
    add(0, 0, 4'd0, 0, 1, 0,  4'd0, 0, 0, 1);
    // periodic, reload 2
    add(0, 1, 4'd2, 0, 1, 1,  4'd2, 0, 0, 0);
    add(0, 0, 4'd0, 1, 1, 1,  4'd2, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd1, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd0, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd2, 1, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd1, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd0, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd2, 1, 1, 0);
    add(0, 0, 4'd0, 0, 0, 1,  4'd2, 0, 1, 0);   // CE low holds
    // mid-run load aborts, same-cycle start ignored
    add(0, 1, 4'd8, 0, 1, 1,  4'd8, 0, 0, 0);
    add(0, 0, 4'd0, 1, 1, 1,  4'd8, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd7, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd6, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd5, 0, 1, 0);
    add(0, 1, 4'd9, 1, 1, 1,  4'd9, 0, 0, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd9, 0, 0, 0);   // CE has no effect in IDLE
    add(0, 0, 4'd0, 1, 0, 1,  4'd9, 0, 1, 0);
    add(0, 0, 4'd0, 0, 1, 1,  4'd8, 0, 1, 0);
    add(0, 0, 4'd0, 1, 1, 1,  4'd7, 0, 1, 0);   // start in RUN ignored
    // clear after activity
    add(1, 0, 4'd0, 1, 1, 1,  4'd0, 0, 0, 0);
    add(1, 1, 4'd5, 0, 1, 1,  4'd0, 0, 0, 0);
    add(0, 0, 4'd0, 1, 0, 1,  4'd0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // reload 15 periodic: full count down then back to 15, no underflow
    step(1, 4'd15, 0, 0, 1, 4'd15, 0, 0, 0, "r15_load");
    step(0, 4'd0,  1, 1, 1, 4'd15, 0, 1, 0, "r15_start");
    for (int i = 14; i >= 0; i--) begin
      step(0, 4'd0, 0, 1, 1, W'(i), 0, 1, 0, $sformatf("r15_q%0d", i));
    end
    step(0, 4'd0, 0, 1, 1, 4'd15, 1, 1, 0, "r15_reload");
    step(0, 4'd0, 0, 1, 1, 4'd14, 0, 1, 0, "r15_after");

    // reload 0 periodic: TC on every enabled cycle; mode switch ends at next TC
    step(1, 4'd0, 0, 1, 1, 4'd0, 0, 0, 0, "r0_load");
    step(0, 4'd0, 1, 1, 1, 4'd0, 0, 1, 0, "r0_start");
    step(0, 4'd0, 0, 1, 1, 4'd0, 1, 1, 0, "r0_tc1");
    step(0, 4'd0, 0, 1, 1, 4'd0, 1, 1, 0, "r0_tc2");
    step(0, 4'd0, 0, 0, 1, 4'd0, 0, 1, 0, "r0_ce0");
    step(0, 4'd0, 0, 1, 1, 4'd0, 1, 1, 0, "r0_tc3");
    step(0, 4'd0, 0, 1, 0, 4'd0, 1, 0, 1, "r0_oneshot");
    step(0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 0, "r0_restart");

    // reload 3 periodic with CE toggling: TC every 8 clocks
    step(1, 4'd3, 0, 0, 1, 4'd3, 0, 0, 0, "tog_load");
    step(0, 4'd0, 1, 0, 1, 4'd3, 0, 1, 0, "tog_start");
    tc_seen = 0;
    last_tc = -1;
    for (int k = 1; k <= 24; k++) begin
      bus.ce = (k % 2 == 1);
      @(posedge c);
      #1;
      if (bus.tc === 1'b1) begin
        if (last_tc >= 0) check("tog_interval", 32'(cyc - last_tc), 32'd8);
        else check("tog_first_tc_cycle", 32'(k), 32'd7);
        last_tc = cyc;
        tc_seen++;
      end
      if (bus.busy !== 1'b1) check("tog_busy", 32'(bus.busy), 32'd1);
    end
    check("tog_pulses", 32'(tc_seen), 32'd3);
    check("tog_q_end", 32'(bus.q), 32'd3);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
